vending_param_fsm: RTL and testbench

//  Parametrised vending controller. Accepts 5/10/25 coins and accumulates credit in

---
 rtl/vending_param_fsm.sv | 106 ++++++++++
 tb/tb_vending_param_fsm.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/vending_param_fsm.sv
// Parametrised vending controller: accumulates 5/10/25 coins as 5-unit credit, vends at PRICE,
// and pays change or a cancel refund back as a train of one-cycle chg5 pulses.
module vending_param_fsm #(
    parameter int unsigned PRICE    = 4,
    parameter int unsigned CREDIT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                dispense,
    output logic                chg5,
    output logic                busy,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit
);

    localparam int unsigned SumW = CREDIT_W + 1;
    localparam logic [SumW-1:0]     PriceW = SumW'(PRICE);
    localparam logic [CREDIT_W-1:0] One    = CREDIT_W'(1);

    typedef enum logic {StCollect, StChange} state_t;

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [CREDIT_W-1:0] r_chg_cnt, w_chg_cnt_nxt;
    logic                r_dispense, w_dispense_nxt;
    logic                r_coin_rej, w_coin_rej_nxt;
    logic [SumW-1:0]     w_coin_val;
    logic [SumW-1:0]     w_sum;
    logic [CREDIT_W-1:0] w_diff;

    always_comb begin
        w_coin_val = '0;
        case (coin)
            2'b01:   w_coin_val = SumW'(1);
            2'b10:   w_coin_val = SumW'(2);
            2'b11:   w_coin_val = SumW'(5);
            default: w_coin_val = '0;
        endcase
    end

    assign w_sum  = {1'b0, r_credit} + w_coin_val;
    // Real difference always fits CREDIT_W, so the modular low-bit subtract is exact.
    assign w_diff = w_sum[CREDIT_W-1:0] - PriceW[CREDIT_W-1:0];

    always_comb begin
        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_chg_cnt_nxt  = r_chg_cnt;
        w_dispense_nxt = 1'b0;
        w_coin_rej_nxt = 1'b0;
        unique case (r_state)
            StCollect: begin
                if (cancel && (w_sum != '0)) begin
                    // Refund includes any coin landing in the same cycle; cancel beats vend.
                    w_credit_nxt  = '0;
                    w_chg_cnt_nxt = w_sum[CREDIT_W-1:0];
                    w_state_nxt   = StChange;
                end else if (w_sum >= PriceW) begin
                    w_dispense_nxt = 1'b1;
                    w_credit_nxt   = '0;
                    if (w_sum != PriceW) begin
                        w_chg_cnt_nxt = w_diff;
                        w_state_nxt   = StChange;
                    end
                end else begin
                    w_credit_nxt = w_sum[CREDIT_W-1:0];
                end
            end
            StChange: begin
                w_chg_cnt_nxt = r_chg_cnt - One;
                if (r_chg_cnt == One) begin
                    w_state_nxt = StCollect;
                end
                if (coin != 2'b00) begin
                    w_coin_rej_nxt = 1'b1;
                end
            end
            default: w_state_nxt = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StCollect;
            r_credit   <= '0;
            r_chg_cnt  <= '0;
            r_dispense <= 1'b0;
            r_coin_rej <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_chg_cnt  <= w_chg_cnt_nxt;
            r_dispense <= w_dispense_nxt;
            r_coin_rej <= w_coin_rej_nxt;
        end
    end

    assign dispense = r_dispense;
    assign coin_rej = r_coin_rej;
    assign busy     = (r_state == StChange);
    assign chg5     = (r_state == StChange);
    assign credit   = r_credit;

endmodule

// File: tb/tb_vending_param_fsm.sv
// Directed bench for vending_param_fsm: a PRICE=4 instance driven from a vector table and a
// PRICE=7 instance driven by hand sequences, including an asynchronous reset mid-change.
module tb_vending_param_fsm;

    localparam logic [1:0] CN = 2'b00;
    localparam logic [1:0] C5 = 2'b01;
    localparam logic [1:0] C10 = 2'b10;
    localparam logic [1:0] C25 = 2'b11;

    typedef struct {
        logic [1:0] coin;
        logic       cancel;
        logic [8:0] exp;   // {dispense, chg5, busy, coin_rej, credit[4:0]}
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_a = 1'b0;
    logic       rst_b = 1'b0;
    logic [1:0] coin_a = 2'b00;
    logic [1:0] coin_b = 2'b00;
    logic       cancel_a = 1'b0;
    logic       cancel_b = 1'b0;
    logic       disp_a, chg5_a, busy_a, rej_a;
    logic       disp_b, chg5_b, busy_b, rej_b;
    logic [4:0] credit_a, credit_b;

    int n_chk = 0;
    int n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    vending_param_fsm #(.PRICE(4), .CREDIT_W(5)) u_dut_a (
        .clk      (clk),
        .rst      (rst_a),
        .coin     (coin_a),
        .cancel   (cancel_a),
        .dispense (disp_a),
        .chg5     (chg5_a),
        .busy     (busy_a),
        .coin_rej (rej_a),
        .credit   (credit_a)
    );

    vending_param_fsm #(.PRICE(7), .CREDIT_W(5)) u_dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .coin     (coin_b),
        .cancel   (cancel_b),
        .dispense (disp_b),
        .chg5     (chg5_b),
        .busy     (busy_b),
        .coin_rej (rej_b),
        .credit   (credit_b)
    );

    function automatic logic [8:0] outs_a();
        return {disp_a, chg5_a, busy_a, rej_a, credit_a};
    endfunction

    function automatic logic [8:0] outs_b();
        return {disp_b, chg5_b, busy_b, rej_b, credit_b};
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got d/c/b/r=%b credit=%0d, want d/c/b/r=%b credit=%0d",
                     name, act[8:5], act[4:0], exp[8:5], exp[4:0]);
        end
    endtask

    task automatic add(input logic [1:0] c, input logic can, input logic d, input logic ch,
                       input logic b, input logic r, input int cr);
        vec_t v;
        v.coin   = c;
        v.cancel = can;
        v.exp    = {d, ch, b, r, 5'(cr)};
        vecs.push_back(v);
    endtask

    // Drive at negedge, then sample 2 ns after the following posedge.
    task automatic step_b(input string name, input logic [1:0] c, input logic can,
                          input logic [8:0] exp);
        @(negedge clk);
        coin_b   = c;
        cancel_b = can;
        @(posedge clk);
        #2;
        check(name, outs_b(), exp);
    endtask

    initial begin
        //  coin can  d  c  b  r  credit
        add(C10, 0,   0, 0, 0, 0, 2);  // 10,10 -> exact vend
        add(C10, 0,   1, 0, 0, 0, 0);
        add(CN,  0,   0, 0, 0, 0, 0);
        add(C5,  0,   0, 0, 0, 0, 1);  // 5,10,10 -> vend + 1 change
        add(C10, 0,   0, 0, 0, 0, 3);
        add(C10, 0,   1, 1, 1, 0, 0);
        add(CN,  0,   0, 0, 0, 0, 0);
        add(C5,  0,   0, 0, 0, 0, 1);  // 5,25 -> vend + 2 change
        add(C25, 0,   1, 1, 1, 0, 0);
        add(CN,  0,   0, 1, 1, 0, 0);
        add(CN,  0,   0, 0, 0, 0, 0);
        add(C5,  0,   0, 0, 0, 0, 1);  // 5,10, cancel -> 3 refund pulses
        add(C10, 0,   0, 0, 0, 0, 3);
        add(CN,  1,   0, 1, 1, 0, 0);
        add(CN,  0,   0, 1, 1, 0, 0);
        add(CN,  1,   0, 1, 1, 0, 0);  // cancel in CHANGE ignored
        add(CN,  0,   0, 0, 0, 0, 0);
        add(C25, 0,   1, 1, 1, 0, 0);  // 25 then coin during CHANGE -> rejected
        add(C5,  0,   0, 0, 0, 1, 0);
        add(CN,  0,   0, 0, 0, 0, 0);
        add(CN,  1,   0, 0, 0, 0, 0);  // cancel with zero credit ignored
        add(C10, 0,   0, 0, 0, 0, 2);  // back-to-back vends
        add(C10, 0,   1, 0, 0, 0, 0);
        add(C10, 0,   0, 0, 0, 0, 2);
        add(C10, 0,   1, 0, 0, 0, 0);
        add(C10, 0,   0, 0, 0, 0, 2);  // coin + cancel same cycle: refund beats vend
        add(C10, 1,   0, 1, 1, 0, 0);
        add(C5,  0,   0, 1, 1, 1, 0);
        add(CN,  0,   0, 1, 1, 0, 0);
        add(CN,  0,   0, 1, 1, 0, 0);
        add(CN,  0,   0, 0, 0, 0, 0);
        add(C5,  0,   0, 0, 0, 0, 1);  // credit climbs to PRICE-1 then vends
        add(C5,  0,   0, 0, 0, 0, 2);
        add(C5,  0,   0, 0, 0, 0, 3);
        add(C5,  0,   1, 0, 0, 0, 0);
        add(CN,  0,   0, 0, 0, 0, 0);

        #3;
        check("reset_a", outs_a(), 9'd0);
        check("reset_b", outs_b(), 9'd0);
        @(negedge clk);
        rst_a = 1'b1;
        rst_b = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            coin_a   = vecs[i].coin;
            cancel_a = vecs[i].cancel;
            @(posedge clk);
            #2;
            check($sformatf("vec_a[%0d]", i), outs_a(), vecs[i].exp);
        end

        // PRICE=7: 25,10 -> exact vend, no change
        step_b("b_25", C25, 1'b0, {4'b0000, 5'd5});
        step_b("b_25_10", C10, 1'b0, {4'b1000, 5'd0});
        step_b("b_idle", CN, 1'b0, {4'b0000, 5'd0});
        // 25,25 -> vend with 3 change, then async reset mid-CHANGE
        step_b("b_25b", C25, 1'b0, {4'b0000, 5'd5});
        step_b("b_25_25", C25, 1'b0, {4'b1110, 5'd0});
        coin_b = CN;
        #1;
        rst_b = 1'b0;
        #1;
        check("b_async_rst", outs_b(), 9'd0);
        @(negedge clk);
        rst_b = 1'b1;
        step_b("b_post_rst", CN, 1'b0, {4'b0000, 5'd0});
        step_b("b_accept", C5, 1'b0, {4'b0000, 5'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
